// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for a 5-stage pipeline: PC/stage-register enables and flushes,
// load-use bubbles, branch squash, memory freeze with timeout, and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned RESET_HOLD  = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_Wreg_addr,
  input  logic             mem_Branch,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err,
  output logic [1:0]       state_dbg
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_mem_err;

  state_t            w_state_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_lu;
  logic              w_act;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic              w_err_set;
  logic              w_pc_en;
  logic              w_ifid_en;
  logic              w_idex_en;
  logic              w_exmem_en;
  logic              w_memwb_en;
  logic              w_ifid_flush;
  logic              w_idex_flush;
  logic              w_exmem_flush;

  // Load-use: EX load writes a register the ID instruction reads
  assign w_lu = ex_MemRead && (ex_Wreg_addr != 5'd0) &&
                ((ex_Wreg_addr == id_rs) || (id_uses_rt && (ex_Wreg_addr == id_rt)));

  assign w_wait_inc = r_wait + WAIT_W'(1);

  // Frozen/error paths leave everything at zero; w_act selects normal sequencing
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_wait_nxt    = r_wait;
    w_act         = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_err_set     = 1'b0;
    w_pc_en       = 1'b0;
    w_ifid_en     = 1'b0;
    w_idex_en     = 1'b0;
    w_exmem_en    = 1'b0;
    w_memwb_en    = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;

    unique case (r_state)
      ST_INIT: begin
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_flush = 1'b1;
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = WAIT_W'(1);
          w_stall_inc = 1'b1;
        end else begin
          w_act = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!mem_ready) begin
          w_stall_inc = 1'b1;
          w_wait_nxt  = w_wait_inc;
          if (w_wait_inc == WAIT_LIMIT) begin
            w_state_nxt = ST_ERR;
            w_err_set   = 1'b1;
          end
        end else begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
          w_act       = 1'b1;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
    endcase

    // Branch squash outranks the load-use bubble
    if (w_act) begin
      if (mem_Branch) begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_flush = 1'b1;
        w_flush_inc   = 1'b1;
      end else if (w_lu) begin
        w_idex_en    = 1'b1;
        w_idex_flush = 1'b1;
        w_exmem_en   = 1'b1;
        w_memwb_en   = 1'b1;
        w_stall_inc  = 1'b1;
      end else begin
        w_pc_en    = 1'b1;
        w_ifid_en  = 1'b1;
        w_idex_en  = 1'b1;
        w_exmem_en = 1'b1;
        w_memwb_en = 1'b1;
      end
    end
  end

  // State updates on the falling edge, alongside the stage registers
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_INIT;
      r_hold      <= '0;
      r_wait      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_wait  <= w_wait_nxt;
      if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_err_set) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Controls are forced low for as long as reset is held
  assign pc_en       = RST_N & w_pc_en;
  assign ifid_en     = RST_N & w_ifid_en;
  assign idex_en     = RST_N & w_idex_en;
  assign exmem_en    = RST_N & w_exmem_en;
  assign memwb_en    = RST_N & w_memwb_en;
  assign ifid_flush  = RST_N & w_ifid_flush;
  assign idex_flush  = RST_N & w_idex_flush;
  assign exmem_flush = RST_N & w_exmem_flush;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_err     = r_mem_err;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (16-bit and 4-bit counters)
// driven identically and checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int RH = 4;
  localparam int MT = 64;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mr;
    logic [4:0] wr;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct {
    logic [7:0] ctl;
    int         st;
    int         err;
    int         stall;
    int         flush;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_Wreg_addr = '0;
  logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0, mem_Branch = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  wire [7:0]  ctl16, ctl4;
  wire [15:0] stall16, flush16;
  wire [3:0]  stall4, flush4;
  wire        err16, err4;
  wire [1:0]  st16, st4;

  pipe_hazard_ctrl #(.RESET_HOLD(RH), .MEM_TIMEOUT(MT), .CNT_W(16)) u_dut16 (
    .CLK(CLK), .RST_N(RST_N), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_Wreg_addr(ex_Wreg_addr), .mem_Branch(mem_Branch),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(ctl16[7]), .ifid_en(ctl16[6]), .idex_en(ctl16[5]), .exmem_en(ctl16[4]),
    .memwb_en(ctl16[3]), .ifid_flush(ctl16[2]), .idex_flush(ctl16[1]), .exmem_flush(ctl16[0]),
    .stall_cnt(stall16), .flush_cnt(flush16), .mem_err(err16), .state_dbg(st16)
  );

  pipe_hazard_ctrl #(.RESET_HOLD(RH), .MEM_TIMEOUT(MT), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_Wreg_addr(ex_Wreg_addr), .mem_Branch(mem_Branch),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(ctl4[7]), .ifid_en(ctl4[6]), .idex_en(ctl4[5]), .exmem_en(ctl4[4]),
    .memwb_en(ctl4[3]), .ifid_flush(ctl4[2]), .idex_flush(ctl4[1]), .exmem_flush(ctl4[0]),
    .stall_cnt(stall4), .flush_cnt(flush4), .mem_err(err4), .state_dbg(st4)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: mode 0=INIT 1=RUN 2=WAIT 3=ERR; counts are unbounded, clipped on compare
  int m_mode = 0, m_init_cycles = 0, m_wait = 0, m_stall = 0, m_flush = 0, m_err = 0;

  function automatic void chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, expv);
    end
  endfunction

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic stim_t mk(input int rs, input int rt, input int urt, input int mr,
                               input int wr, input int br, input int req, input int rdy);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.urt = 1'(urt); s.mr = 1'(mr);
    s.wr = 5'(wr); s.br = 1'(br); s.req = 1'(req); s.rdy = 1'(rdy);
    return s;
  endfunction

  // Drive one cycle after the rising edge, predict the response, advance the model
  task automatic step(input stim_t s, input logic rst);
    exp_t e;
    bit   lu;
    bit   act;
    @(posedge CLK);
    cyc++;
    RST_N = rst; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt; ex_MemRead = s.mr;
    ex_Wreg_addr = s.wr; mem_Branch = s.br; mem_req = s.req; mem_ready = s.rdy;
    lu  = s.mr && (s.wr != 0) && ((s.wr == s.rs) || (s.urt && (s.wr == s.rt)));
    act = 1'b0;
    if (!rst) begin
      m_mode = 0; m_init_cycles = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 0;
      e.ctl = 8'h00;
    end else begin
      e.ctl = 8'h00;
      case (m_mode)
        0: e.ctl = 8'b0111_1111;
        1: act = !(s.req && !s.rdy);
        2: act = s.rdy;
        default: ;
      endcase
      if (act) begin
        if (s.br)    e.ctl = 8'b1111_1111;
        else if (lu) e.ctl = 8'b0011_1010;
        else         e.ctl = 8'b1111_1000;
      end
    end
    e.st = m_mode; e.err = m_err; e.stall = m_stall; e.flush = m_flush;
    exp_q.push_back(e);
    if (rst) begin
      case (m_mode)
        0: begin
          m_init_cycles++;
          if (m_init_cycles == RH) m_mode = 1;
        end
        1: if (!act) begin m_mode = 2; m_wait = 1; m_stall++; end
        2: if (!act) begin
          m_stall++; m_wait++;
          if (m_wait == MT) begin m_mode = 3; m_err = 1; end
        end else begin
          m_mode = 1; m_wait = 0;
        end
        default: ;
      endcase
      if (act) begin
        if (s.br)    m_flush++;
        else if (lu) m_stall++;
      end
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-high-phase, well before the falling edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl16", int'(ctl16), int'(e.ctl));
        chk("ctl4", int'(ctl4), int'(e.ctl));
        chk("state", int'(st16), e.st);
        chk("state4", int'(st4), e.st);
        chk("mem_err", int'(err16), e.err);
        chk("mem_err4", int'(err4), e.err);
        chk("stall16", int'(stall16), clip(e.stall, 65535));
        chk("flush16", int'(flush16), clip(e.flush, 65535));
        chk("stall4", int'(stall4), clip(e.stall, 15));
        chk("flush4", int'(flush4), clip(e.flush, 15));
      end
    end
  end

  initial begin
    stim_t idle;
    stim_t s;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset and fill
    repeat (2) step(idle, 1'b0);
    repeat (6) step(idle, 1'b1);

    // Load-use variants
    step(mk(5, 0, 0, 1, 5, 0, 0, 0), 1'b1);
    step(mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b1);
    step(mk(1, 5, 0, 1, 5, 0, 0, 0), 1'b1);
    step(mk(1, 5, 1, 1, 5, 0, 0, 0), 1'b1);
    step(idle, 1'b1);

    // Branch together with load-use
    step(mk(5, 0, 0, 1, 5, 1, 0, 0), 1'b1);
    step(idle, 1'b1);

    // Three frozen cycles then release with a taken branch
    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    step(mk(0, 0, 0, 0, 0, 1, 1, 1), 1'b1);
    repeat (2) step(idle, 1'b1);

    // Load-use on the release cycle
    step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    step(mk(3, 0, 0, 1, 3, 0, 1, 1), 1'b1);

    // Memory timeout into ERR, sticky until reset
    repeat (70) step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    repeat (5) step(mk(2, 0, 0, 1, 2, 1, 1, 1), 1'b1);
    step(idle, 1'b0);
    repeat (RH + 1) step(idle, 1'b1);

    // Counter saturation on the narrow instance
    repeat (20) step(mk(7, 0, 0, 1, 7, 0, 0, 0), 1'b1);
    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
    step(idle, 1'b0);
    step(idle, 1'b1);
    repeat (2) step(idle, 1'b0);
    repeat (RH + 2) step(idle, 1'b1);

    // Randomized traffic with occasional slow-memory bursts and resets
    for (int seg = 0; seg < 60; seg++) begin
      int slow;
      slow = ($urandom % 6 == 0) ? 1 : 0;
      for (int k = 0; k < 50; k++) begin
        s.rs  = 5'($urandom_range(0, 3));
        s.rt  = 5'($urandom_range(0, 3));
        s.wr  = 5'($urandom_range(0, 3));
        s.urt = 1'($urandom % 2);
        s.mr  = 1'($urandom % 3 == 0);
        s.br  = 1'($urandom % 8 == 0);
        s.req = 1'($urandom % 2);
        s.rdy = slow ? 1'($urandom % 20 == 0) : 1'($urandom % 4 != 0);
        step(s, ($urandom % 400 == 0) ? 1'b0 : 1'b1);
      end
    end

    repeat (3) @(posedge CLK);
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
